// File: rtl/byte_mem_pkg.sv
// -----------------------------------------------------------------------------
// byte_mem_pkg
// Shared types and constants for the byte-wide memory responder.
//   state_e      : responder FSM states (IDLE, WAIT, RESP)
//   WAIT_CNT_W   : width of the wait-state counter
//   DATA_W       : data byte width
//   RAM_W        : stored word width (DATA_W, plus one parity bit when
//                  MEM_PARITY_EN is defined)
//   even_parity  : parity bit that makes the stored word's popcount even
// Optional feature macro: MEM_PARITY_EN
// -----------------------------------------------------------------------------
package byte_mem_pkg;

   localparam int WAIT_CNT_W = 4;
   localparam int DATA_W     = 8;

`ifdef MEM_PARITY_EN
   localparam int RAM_W = DATA_W + 1;
`else
   localparam int RAM_W = DATA_W;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/byte_ram.sv
// -----------------------------------------------------------------------------
// byte_ram
// Single-port storage array: synchronous write, registered read.
// The read register only updates on a read access, so it holds the last
// read word between accesses. Array contents are not reset.
// Ports:
//   clk, rst_n : clock, async active-low reset (read register only)
//   en, we     : access enable, write select (en && !we is a read)
//   addr       : word address
//   wdata      : word to store (RAM_W bits)
//   rdata      : registered read word (RAM_W bits)
// Word width follows MEM_PARITY_EN through byte_mem_pkg::RAM_W.
// -----------------------------------------------------------------------------
module byte_ram
   import byte_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [RAM_W-1:0]      wdata,
   output logic [RAM_W-1:0]      rdata
);

   logic [RAM_W-1:0] mem_q [2**ADDR_WIDTH];
   logic [RAM_W-1:0] rdata_q;
   logic [RAM_W-1:0] rdata_d;

   // Read register next value: capture the addressed word only on a read.
   always_comb begin
      rdata_d = rdata_q;
      if (en && !we) begin
         rdata_d = mem_q[addr];
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Storage write port; contents deliberately have no reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem_q[addr] <= wdata;
      end
   end

   // Read register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/byte_mem_responder.sv
// -----------------------------------------------------------------------------
// byte_mem_responder
// Byte-wide memory responder for the multicycle CPU. Accepts one read or
// write request when idle, inserts WAIT_CYCLES wait states, performs the
// array access and reports completion with one-cycle strobes.
// Parameters:
//   ADDR_WIDTH  : address width, array depth 2**ADDR_WIDTH bytes
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
// Ports:
//   ph1        in  clock, rising edge
//   reset_n    in  async active-low reset
//   mem_read   in  read request (level)
//   mem_write  in  write request (level)
//   addr       in  byte address, sampled with the request
//   wdata      in  store byte, sampled with the request
//   rdata      out read byte, held until the next read response
//   rvalid     out one-cycle pulse, rdata valid
//   wack       out one-cycle pulse, write committed
//   busy       out request in flight (acceptance through response cycle)
//   req_err    out one-cycle pulse, request rejected
//   parity_err out one-cycle pulse with rvalid on stored parity mismatch
// Optional feature macro: MEM_PARITY_EN (9-bit array with even parity);
// without it parity_err is tied low.
// -----------------------------------------------------------------------------
module byte_mem_responder
   import byte_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  ph1,
   input  logic                  reset_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata,
   output logic                  rvalid,
   output logic                  wack,
   output logic                  busy,
   output logic                  req_err,
   output logic                  parity_err
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

   state_e                 state_q,   state_d;
   logic [WAIT_CNT_W-1:0]  cnt_q,     cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
   logic [DATA_W-1:0]      wdata_q,   wdata_d;
   logic                   dir_rd_q,  dir_rd_d;
   logic                   busy_q,    busy_d;
   logic                   rvalid_q,  rvalid_d;
   logic                   wack_q,    wack_d;
   logic                   req_err_q, req_err_d;

   logic                   req_any_s;
   logic                   req_one_s;
   logic                   ram_en_s;
   logic                   ram_we_s;
   logic [RAM_W-1:0]       ram_wdata_s;
   logic [RAM_W-1:0]       ram_rdata_s;

   assign req_any_s = mem_read | mem_write;
   assign req_one_s = mem_read ^ mem_write;

   // Next-state, datapath latches and strobes.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      dir_rd_d  = dir_rd_q;
      rvalid_d  = 1'b0;
      wack_d    = 1'b0;
      req_err_d = 1'b0;
      ram_en_s  = 1'b0;
      ram_we_s  = 1'b0;

      case (state_q)
         IDLE: begin
            // busy_q still high here means this is the response cycle;
            // holding off acceptance guarantees a busy-low gap between accepts.
            if (req_any_s && (busy_q || !req_one_s)) begin
               req_err_d = 1'b1;
            end else if (req_one_s) begin
               addr_d   = addr;
               wdata_d  = wdata;
               dir_rd_d = mem_read;
               cnt_d    = WAIT_LOAD;
               state_d  = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            req_err_d = req_any_s;
            if (cnt_q == {WAIT_CNT_W{1'b0}}) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
            end
         end
         RESP: begin
            req_err_d = req_any_s;
            ram_en_s  = 1'b1;
            ram_we_s  = ~dir_rd_q;
            rvalid_d  = dir_rd_q;
            wack_d    = ~dir_rd_q;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Busy covers acceptance through the cycle the strobe is visible.
      busy_d = (state_d != IDLE) || (state_q == RESP);
   end

   // Control and request-latch registers.
   always_ff @(posedge ph1 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         dir_rd_q  <= 1'b0;
         busy_q    <= 1'b0;
         rvalid_q  <= 1'b0;
         wack_q    <= 1'b0;
         req_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         dir_rd_q  <= dir_rd_d;
         busy_q    <= busy_d;
         rvalid_q  <= rvalid_d;
         wack_q    <= wack_d;
         req_err_q <= req_err_d;
      end
   end

`ifdef MEM_PARITY_EN
   assign ram_wdata_s = {even_parity(wdata_q), wdata_q};
   // Mismatch is judged on the registered read word, so it lines up with rvalid.
   assign parity_err  = rvalid_q &&
                        (even_parity(ram_rdata_s[DATA_W-1:0]) != ram_rdata_s[DATA_W]);
`else
   assign ram_wdata_s = wdata_q;
   assign parity_err  = 1'b0;
`endif

   byte_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (ph1),
      .rst_n (reset_n),
      .en    (ram_en_s),
      .we    (ram_we_s),
      .addr  (addr_q),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   assign rdata   = ram_rdata_s[DATA_W-1:0];
   assign rvalid  = rvalid_q;
   assign wack    = wack_q;
   assign busy    = busy_q;
   assign req_err = req_err_q;

endmodule

// File: tb/tb_byte_mem_responder.sv
// Bench: three responders (WAIT_CYCLES 0, 3, 4) share one stimulus stream.
// A per-responder behavioural model (absolute edge numbers for the response,
// a plain byte array for memory) predicts every output each cycle.
module tb_byte_mem_responder;

   localparam int WC [3] = '{0, 3, 4};

   logic       ph1 = 1'b0;
   logic       reset_n;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] addr;
   logic [7:0] wdata;

   logic [7:0] rdata_s      [3];
   logic       rvalid_s     [3];
   logic       wack_s       [3];
   logic       busy_s       [3];
   logic       req_err_s    [3];
   logic       parity_err_s [3];

   int n_pass  = 0;
   int n_total = 0;

   always #5 ph1 = ~ph1;

   byte_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
      .ph1(ph1), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata_s[0]), .rvalid(rvalid_s[0]),
      .wack(wack_s[0]), .busy(busy_s[0]), .req_err(req_err_s[0]),
      .parity_err(parity_err_s[0]));

   byte_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_dut1 (
      .ph1(ph1), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata_s[1]), .rvalid(rvalid_s[1]),
      .wack(wack_s[1]), .busy(busy_s[1]), .req_err(req_err_s[1]),
      .parity_err(parity_err_s[1]));

   byte_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(4)) u_dut2 (
      .ph1(ph1), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata_s[2]), .rvalid(rvalid_s[2]),
      .wack(wack_s[2]), .busy(busy_s[2]), .req_err(req_err_s[2]),
      .parity_err(parity_err_s[2]));

   task automatic chk(input string name, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s dut%0d (wait=%0d): got %0h expected %0h",
                  name, k, WC[k], act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [7:0] a);
      return a * 8'd3 + 8'h11;
   endfunction

   // ---------------- behavioural model ----------------
   logic [7:0] m_mem   [3][256];
   bit         m_flip  [3][256];
   bit         m_pend  [3];
   int         m_resp  [3];
   bit         m_rd    [3];
   logic [7:0] m_addr  [3];
   logic [7:0] m_wdata [3];
   bit         e_busy  [3];
   bit         e_rvalid[3];
   bit         e_wack  [3];
   bit         e_rerr  [3];
   bit         e_perr  [3];
   logic [7:0] e_rdata [3];
   int         ecnt = 0;
   bit         prev_b;

   always @(posedge ph1) begin
      if (!reset_n) begin
         for (int k = 0; k < 3; k++) begin
            m_pend[k] = 0; e_busy[k] = 0; e_rvalid[k] = 0; e_wack[k] = 0;
            e_rerr[k] = 0; e_perr[k] = 0; e_rdata[k] = 8'h00;
         end
      end else begin
         ecnt++;
         for (int k = 0; k < 3; k++) begin
            prev_b = e_busy[k];
            e_rvalid[k] = 0; e_wack[k] = 0; e_rerr[k] = 0; e_perr[k] = 0;
            if (m_pend[k] && ecnt == m_resp[k]) begin
               if (m_rd[k]) begin
                  e_rdata[k]  = m_mem[k][m_addr[k]];
                  e_rvalid[k] = 1;
`ifdef MEM_PARITY_EN
                  e_perr[k]   = m_flip[k][m_addr[k]];
`endif
               end else begin
                  m_mem[k][m_addr[k]]  = m_wdata[k];
                  m_flip[k][m_addr[k]] = 0;
                  e_wack[k] = 1;
               end
            end
            if (m_pend[k] && ecnt > m_resp[k]) m_pend[k] = 0;
            if ((mem_read || mem_write) && (prev_b || (mem_read && mem_write))) begin
               e_rerr[k] = 1;
            end else if (mem_read || mem_write) begin
               m_pend[k]  = 1;
               m_resp[k]  = ecnt + 1 + WC[k];
               m_rd[k]    = mem_read;
               m_addr[k]  = addr;
               m_wdata[k] = wdata;
            end
            e_busy[k] = m_pend[k] && (ecnt <= m_resp[k]);
         end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rdata",      k, {24'h0, rdata_s[k]},     {24'h0, e_rdata[k]});
         chk("rvalid",     k, {31'h0, rvalid_s[k]},    {31'h0, e_rvalid[k]});
         chk("wack",       k, {31'h0, wack_s[k]},      {31'h0, e_wack[k]});
         chk("busy",       k, {31'h0, busy_s[k]},      {31'h0, e_busy[k]});
         chk("req_err",    k, {31'h0, req_err_s[k]},   {31'h0, e_rerr[k]});
         chk("parity_err", k, {31'h0, parity_err_s[k]},{31'h0, e_perr[k]});
      end
   end

   // ---------------- directed transaction recorder ----------------
   int         st_idx [3];
   int         st_cnt [3];
   int         bz_cnt [3];
   int         re_cnt [3];
   logic [7:0] st_data[3];
   logic       st_perr[3];

   task automatic do_op(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input bit reassert);
      for (int k = 0; k < 3; k++) begin
         st_idx[k] = -1; st_cnt[k] = 0; bz_cnt[k] = 0; re_cnt[k] = 0;
         st_data[k] = 8'h00; st_perr[k] = 1'b0;
      end
      @(negedge ph1);
      mem_read = rd; mem_write = wr; addr = a; wdata = d;
      for (int i = 0; i < 10; i++) begin
         @(posedge ph1); #2;
         for (int k = 0; k < 3; k++) begin
            if (rvalid_s[k] || wack_s[k]) begin
               if (st_cnt[k] == 0) begin
                  st_idx[k] = i; st_data[k] = rdata_s[k]; st_perr[k] = parity_err_s[k];
               end
               st_cnt[k]++;
            end
            if (busy_s[k])    bz_cnt[k]++;
            if (req_err_s[k]) re_cnt[k]++;
         end
         @(negedge ph1);
         mem_read  = reassert && (i == 1);
         mem_write = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = 8'h00; wdata = 8'h00;
      repeat (2) @(posedge ph1);
      @(negedge ph1) reset_n = 1'b1;

      for (int a = 0; a < 256; a++) do_op(1'b0, 1'b1, 8'(a), pat(8'(a)), 1'b0);

      // write 0xA5 @ 0x10, read it back
      do_op(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("wr_strobe_delay", k, st_idx[k], 1 + WC[k]);
         chk("wr_strobe_count", k, st_cnt[k], 1);
         chk("wr_busy_cycles",  k, bz_cnt[k], 2 + WC[k]);
      end
      do_op(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("rd_strobe_delay", k, st_idx[k], 1 + WC[k]);
         chk("rd_data_10",      k, {24'h0, st_data[k]}, 32'h0000_00A5);
      end

      // read 0x20 = 0x3C with a rejected re-request while busy
      do_op(1'b0, 1'b1, 8'h20, 8'h3C, 1'b0);
      do_op(1'b1, 1'b0, 8'h20, 8'h00, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("busy_rd_cycles", k, bz_cnt[k], 2 + WC[k]);
         chk("single_rvalid",  k, st_cnt[k], 1);
         chk("reassert_err",   k, re_cnt[k], 1);
         chk("rd_data_20",     k, {24'h0, st_data[k]}, 32'h0000_003C);
      end
      chk("busy5_wait3", 1, bz_cnt[1], 5);

      // both requests high: rejected, no write
      do_op(1'b1, 1'b1, 8'h05, 8'hFF, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("both_err",    k, re_cnt[k], 1);
         chk("both_no_ack", k, st_cnt[k], 0);
      end
      do_op(1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) chk("rd_data_05", k, {24'h0, st_data[k]}, 32'h0000_0020);

      // top address, and address 0 unaffected
      do_op(1'b0, 1'b1, 8'hFF, 8'h96, 1'b0);
      do_op(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) chk("rd_data_ff", k, {24'h0, st_data[k]}, 32'h0000_0096);
      do_op(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) chk("rd_data_00", k, {24'h0, st_data[k]}, 32'h0000_0011);

      // reset during WAIT aborts the write (wait 0 has already committed)
      @(negedge ph1);
      mem_write = 1'b1; addr = 8'h30; wdata = 8'h77;
      @(posedge ph1);
      @(negedge ph1) mem_write = 1'b0;
      @(posedge ph1);
      @(negedge ph1) reset_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_outputs", k,
             {24'h0, rdata_s[k]} | {31'h0, rvalid_s[k]} | {31'h0, wack_s[k]} |
             {31'h0, busy_s[k]} | {31'h0, req_err_s[k]} | {31'h0, parity_err_s[k]},
             32'h0);
      end
      repeat (2) @(posedge ph1);
      @(negedge ph1) reset_n = 1'b1;
      do_op(1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
      chk("rd_30_committed", 0, {24'h0, st_data[0]}, 32'h0000_0077);
      chk("rd_30_aborted",   1, {24'h0, st_data[1]}, 32'h0000_00A1);
      chk("rd_30_aborted",   2, {24'h0, st_data[2]}, 32'h0000_00A1);

      // parity
      do_op(1'b0, 1'b1, 8'h40, 8'h01, 1'b0);
`ifdef MEM_PARITY_EN
      u_dut0.u_ram.mem_q[8'h40][8] = ~u_dut0.u_ram.mem_q[8'h40][8];
      u_dut1.u_ram.mem_q[8'h40][8] = ~u_dut1.u_ram.mem_q[8'h40][8];
      u_dut2.u_ram.mem_q[8'h40][8] = ~u_dut2.u_ram.mem_q[8'h40][8];
      for (int k = 0; k < 3; k++) m_flip[k][8'h40] = 1'b1;
      do_op(1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("parity_err_hit", k, {31'h0, st_perr[k]}, 32'h1);
         chk("parity_rdata",   k, {24'h0, st_data[k]}, 32'h0000_0001);
      end
`else
      do_op(1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("parity_err_off", k, {31'h0, st_perr[k]}, 32'h0);
         chk("parity_rdata",   k, {24'h0, st_data[k]}, 32'h0000_0001);
      end
`endif

      // random traffic, including requests while busy and dual requests
      for (int i = 0; i < 800; i++) begin
         int r;
         @(negedge ph1);
         r = $urandom_range(0, 9);
         mem_read  = (r == 0) || (r == 2) || (r == 3);
         mem_write = (r == 1) || (r == 2) || (r == 4);
         addr  = 8'($urandom);
         wdata = 8'($urandom);
      end
      @(negedge ph1);
      mem_read = 1'b0; mem_write = 1'b0;
      repeat (10) @(posedge ph1);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/byte_mem_responder.md
# byte_mem_responder

Byte-wide memory responder that serves the read and write requests issued by the multicycle control unit and datapath. Each request carries an address, a direction and, for stores, a write byte. The block accepts the request when idle, inserts a configurable number of wait states, then performs the array access. It reports completion with single-cycle strobes. It sits on the memory side of the IorD address mux and feeds both the instruction-byte registers and the memory data register.

## Interface
- ADDR_WIDTH, 8, address width; array depth is 2**ADDR_WIDTH bytes
- WAIT_CYCLES, 0, wait states inserted between acceptance and response (0..15)
- ph1  in  1  clock, all state updates on rising edge
- reset_n  in  1  one clock; reset is asynchronous and active-low
- mem_read  in  1  read request, level-sampled
- mem_write  in  1  write request, level-sampled
- addr  in  ADDR_WIDTH  byte address, sampled with the request
- wdata  in  8  store byte, sampled with the request
- rdata  out  8  read byte, held until next read response
- rvalid  out  1  one-cycle pulse, rdata valid
- wack  out  1  one-cycle pulse, write committed
- busy  out  1  request in flight
- req_err  out  1  one-cycle pulse, request rejected
- parity_err  out  1  one-cycle pulse with rvalid on parity mismatch

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: exactly one of mem_read or mem_write high at an edge accepts the request.
  - addr, wdata and direction are latched.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT: counter loads WAIT_CYCLES-1 on acceptance and decrements each edge. The state moves to RESP at the edge where the counter is 0.
- RESP, read: array[addr_q] loads into rdata, and rvalid pulses for one cycle.
- RESP, write: array[addr_q] is written with wdata_q, and wack pulses for one cycle.
- RESP always returns to IDLE. Requests are not queued. At least one IDLE cycle separates consecutive accepts.
- Both mem_read and mem_write high in IDLE: no accept, no array access, req_err pulses.
- Request high while busy: ignored, req_err pulses, the in-flight request is unaffected.
- Address arithmetic: no range check. Depth equals 2**ADDR_WIDTH, so every address is valid.
- Array contents are not reset.

## Timing
- Reset values: rdata=0, rvalid=0, wack=0, busy=0, req_err=0, parity_err=0, state IDLE, counter 0.
- Request sampled at edge N. Response strobe (rvalid/wack) is high in the cycle after edge N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: strobe is high one cycle after acceptance.
- busy is high from edge N through the response cycle, and low in the following IDLE cycle.
- A write becomes visible to a read accepted after the wack cycle.
- All outputs are registered; none is combinational from inputs.
- reset_n asserted mid-request: the request is aborted and the state returns to IDLE.
  - A write in WAIT is not committed.
  - No strobe is issued after reset release.

## Configuration
- MEM_PARITY_EN defined:
  - The array is 9 bits wide and stores even parity of wdata on each write.
  - On a read, parity is recomputed. A mismatch pulses parity_err together with rvalid; rdata still returns the stored byte.
- MEM_PARITY_EN undefined:
  - The array is 8 bits wide.
  - parity_err is tied to 0; the port is kept.

## Structure
- Package byte_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - WAIT_CNT_W = 4
  - DATA_W = 8
  - parity helper function
- Sub-module byte_ram holds the storage only: single-port, synchronous write, registered read, width DATA_W or DATA_W+1 under MEM_PARITY_EN.

## Test plan
- WAIT_CYCLES=0: write 0xA5 to 0x10 -> wack high exactly 1 cycle after accept. Read 0x10 -> rvalid 1 cycle after accept with rdata=0xA5.
- WAIT_CYCLES=3: read 0x20 holding 0x3C -> busy for 5 cycles and rvalid 4 cycles after accept with rdata=0x3C. mem_read re-asserted during WAIT -> req_err pulses, single rvalid only.
- mem_read and mem_write both high in IDLE with addr=0x05, wdata=0xFF -> req_err pulse, no wack, then read 0x05 returns the prior value.
- Write at 0xFF with ADDR_WIDTH=8, then read 0xFF -> rdata matches; read 0x00 is unaffected.
- WAIT_CYCLES=4: write 0x77 to 0x30, assert reset_n low during WAIT -> all outputs 0. Subsequent read of 0x30 returns the old value, no wack ever seen.
- MEM_PARITY_EN: write 0x01, force-flip the stored parity bit via hierarchical access, read -> rvalid with parity_err=1 and rdata=0x01. Without the macro, parity_err stays 0.
